// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory and decode handshake bundle for fetch_ctrl
interface fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] Instruction;
  logic [ADDR_W-1:0] Add;
  logic              inst_valid;
  logic              inst_ready;

  // fetch side: drives memory requests and the decode-facing head entry
  modport master (
    output imem_req, imem_addr, Instruction, Add, inst_valid,
    input  imem_data, inst_ready
  );

  // memory/decode side
  modport slave (
    input  imem_req, imem_addr, Instruction, Add, inst_valid,
    output imem_data, inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC, imem requests, 2-entry instruction buffer, branch flush
module fetch_ctrl #(
  parameter int              ADDR_W   = 10,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] TargetAddress,
  input  logic              Halt,
  fetch_ctrl_if.master      bus,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_addr [2];
  logic [CNT_W-1:0]  r_fetch_count;

  logic              w_pop;
  logic              w_req;
  logic              w_wr_idx;
  logic [2:0]        w_demand;
  logic [2:0]        w_space;
  logic [ADDR_W-1:0] w_target;

  // head is always slot 0, so valid is purely a function of occupancy
  assign w_pop    = (r_occ != 2'd0) & bus.inst_ready;
  assign w_demand = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_space  = 3'd2 + {2'b00, w_pop};
  // tail slot after this cycle's pop: occ - pop, only 0 or 1 when a write is legal
  assign w_wr_idx = r_occ[0] ^ w_pop;
  assign w_target = TargetAddress & ~ADDR_W'(3);

  // state register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) r_state <= S_BOOT;
    else        r_state <= w_state_nxt;
  end

  // next state: every state leaves to HALT or RUN purely on the Halt level
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = Halt ? S_HALT : S_RUN;
      S_RUN:   w_state_nxt = Halt ? S_HALT : S_RUN;
      S_HALT:  w_state_nxt = Halt ? S_HALT : S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // outputs: issue only in RUN, not on a redirect, and only if the result fits the buffer
  always_comb begin
    w_req           = (r_state == S_RUN) & ~Branch & (w_demand < w_space);
    bus.imem_req    = w_req;
    bus.imem_addr   = r_pc;
    bus.inst_valid  = (r_occ != 2'd0);
    bus.Instruction = r_buf_data[0];
    bus.Add         = r_buf_addr[0];
    fetch_count     = r_fetch_count;
  end

  // program counter: redirect wins, otherwise advance by one word per issue
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_pc            <= RESET_PC;
      r_inflight      <= 1'b0;
      r_inflight_addr <= RESET_PC;
    end else begin
      r_inflight      <= w_req;
      r_inflight_addr <= r_pc;
      if (Branch)     r_pc <= w_target;
      else if (w_req) r_pc <= r_pc + ADDR_W'(4);
    end
  end

  // instruction buffer: shift on pop, capture response at tail, flush on redirect
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_occ         <= 2'd0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_addr[0] <= '0;
      r_buf_addr[1] <= '0;
    end else if (Branch) begin
      r_occ <= 2'd0;
    end else begin
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_addr[0] <= r_buf_addr[1];
      end
      if (r_inflight) begin
        r_buf_data[w_wr_idx] <= bus.imem_data;
        r_buf_addr[w_wr_idx] <= r_inflight_addr;
      end
      r_occ <= r_occ - {1'b0, w_pop} + {1'b0, r_inflight};
    end
  end

  // delivered-instruction counter, including a pop that coincides with a redirect
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)     r_fetch_count <= '0;
    else if (w_pop) r_fetch_count <= r_fetch_count + CNT_W'(1);
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives the synchronous instruction memory. It issues one fetch request per cycle, absorbs the one-cycle memory latency and decode back-pressure in a 2-entry instruction buffer, and applies branch redirects with flush and squash of stale fetches. It sits between the instruction memory and the decode stage and presents instructions over a valid/ready handshake.

## Interface
- ADDR_W, 10, byte address width of PC and memory address
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0
- CNT_W, 16, width of the delivered-instruction counter

- clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately
- Branch  in  1  redirect request, sampled each cycle
- TargetAddress  in  ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
- Halt  in  1  level; 1 stops issuing new fetches
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address, valid when imem_req=1
- imem_data  in  DATA_W  memory read data, valid exactly 1 cycle after a request
- Instruction  out  DATA_W  buffer head instruction
- Add  out  ADDR_W  address of the buffer head instruction
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  decode accepts head this cycle
- fetch_count  out  CNT_W  number of instructions accepted by decode

## Operation
- States: BOOT, RUN, HALT. Reset -> BOOT. BOOT -> RUN (or HALT if Halt=1) after exactly one cycle. RUN -> HALT when Halt=1; HALT -> RUN when Halt=0. No requests issued in BOOT or HALT.
- Handshake: pop = inst_valid & inst_ready. inst_valid must not depend combinationally on inst_ready; Instruction/Add stable while inst_valid=1 and not popped.
- Buffer: 2 entries {instruction, address}, FIFO order. inflight = 1 when a request was issued last cycle and not squashed.
- Issue rule: imem_req = (state==RUN) & ~Branch & (occupancy + inflight - pop < 2). imem_addr = PC. On issue PC <= PC + 4, modulo 2^ADDR_W (wrap to 0).
- Response: in the cycle after an unsquashed issue, {imem_data, issued address} is written to the buffer tail.
- Branch=1 (any state, priority over all else): a pop occurring that cycle completes normally; all remaining buffer entries cleared; any in-flight response (arriving next cycle) discarded; PC <= {TargetAddress[ADDR_W-1:2], 2'b00}; no request that cycle. State unchanged. Back-to-back Branch: last one wins.
- Halt does not cancel an in-flight response; it is still captured. Buffer drains normally during HALT.
- fetch_count increments by 1 on every pop, wraps at 2^CNT_W.
- Buffer never overflows by construction; a write while full is a design error (assertion in bench).

## Timing
- Reset values: state BOOT, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, Instruction=0, Add=0, buffer empty, inflight=0, fetch_count=0. Reset mid-operation discards everything immediately.
- After Reset rises at edge E0: BOOT during cycle 0, first imem_req in cycle 1 (addr RESET_PC), data returns cycle 2, inst_valid=1 from cycle 3.
- Request-to-valid latency: 2 cycles. Steady state with inst_ready=1: one instruction per cycle, one request per cycle.
- Branch in cycle B: request at target in cycle B+1, inst_valid for target from B+3; inst_valid=0 in B+1 and B+2.
- inst_ready=0: at most 2 instructions held; issuing stops when occupancy+inflight reaches 2, resumes the cycle a pop frees space.

## Test plan
- Reset release, inst_ready=1: requests at 0x000,0x004,0x008... from cycle 1; inst_valid from cycle 3; Add follows 0,4,8; fetch_count=10 after 10 pops.
- Back-pressure: hold inst_ready=0 from cycle 5 for 6 cycles -> exactly 2 entries buffered, imem_req=0 while full, no loss/duplication; resume in order.
- Branch to 0x104 with 2 entries buffered and one in flight -> buffer flushed, in-flight data discarded, next request 0x104 at B+1, next Add=0x104 at B+3.
- Branch with TargetAddress=0x3FF and same-cycle pop -> popped instruction counted, PC=0x3FC, following fetch address wraps 0x3FC -> 0x000.
- Halt=1 for 4 cycles mid-stream -> no new requests, in-flight instruction still delivered, restart at correct sequential PC on Halt=0.
- Reset asserted (0) mid-stream with inst_valid=1 -> outputs and fetch_count clear immediately, sequence restarts per first scenario.
